// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with per-stage valid/ready flow control.
// Optional ovf/zero flags are built only when the CLA_FLAGS_EN macro is defined.
module pipe_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NB    = WIDTH / BLOCK;
  localparam int SPS   = NB / STAGES;
  localparam int CHUNK = SPS * BLOCK;

  // Returns {block G, block P, sum} for one BLOCK-bit lookahead slice.
  function automatic logic [BLOCK+1:0] cla_block(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             ci);
    logic [BLOCK-1:0] g, p, gg, pp, sm;
    g     = x & y;
    p     = x ^ y;
    gg[0] = g[0];
    pp[0] = p[0];
    sm[0] = p[0] ^ ci;
    for (int i = 1; i < BLOCK; i++) begin
      gg[i] = g[i] | (p[i] & gg[i-1]);
      pp[i] = p[i] & pp[i-1];
      sm[i] = p[i] ^ (gg[i-1] | (pp[i-1] & ci));
    end
    return {gg[BLOCK-1], pp[BLOCK-1], sm};
  endfunction

  // Returns {carry out, sum} for the slices one stage resolves.
  function automatic logic [CHUNK:0] cla_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    logic             c;
    logic [CHUNK-1:0] sm;
    logic [BLOCK+1:0] r;
    c = ci;
    for (int j = 0; j < SPS; j++) begin
      r = cla_block(x[j*BLOCK +: BLOCK], y[j*BLOCK +: BLOCK], c);
      sm[j*BLOCK +: BLOCK] = r[BLOCK-1:0];
      c = r[BLOCK+1] | (r[BLOCK] & c);
    end
    return {c, sm};
  endfunction

  logic [WIDTH-1:0]  w_bx;
  logic              w_c0;
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] w_adv;

  assign w_bx = sub ? ~b : b;
  assign w_c0 = sub ? 1'b1 : cin;

  // Handshake: a transfer happens on a rising edge where valid && ready; a stage
  // advances when it is empty or its successor advances, so ready ripples back
  // combinationally from out_ready and a held result never changes.
  always_comb begin : adv_chain
    logic go;
    go    = !r_vld[STAGES-1] || out_ready;
    w_adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k != STAGES - 1) go = !r_vld[k] || go;
      w_adv[k] = go;
    end
  end

  assign in_ready = w_adv[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld <= '0;
    end else begin
      if (w_adv[0]) r_vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) r_vld[k] <= r_vld[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int DONE = (k + 1) * CHUNK;
    localparam int REM  = WIDTH - DONE;

    logic [CHUNK-1:0] w_x, w_y;
    logic             w_ci, w_vin, w_ld;
    logic [CHUNK:0]   w_res;
    logic [DONE-1:0]  w_s_nxt, r_s;
    logic             r_c;

    if (k == 0) begin : g_src
      assign w_x     = a[CHUNK-1:0];
      assign w_y     = w_bx[CHUNK-1:0];
      assign w_ci    = w_c0;
      assign w_vin   = in_valid;
      assign w_s_nxt = w_res[CHUNK-1:0];
    end else begin : g_src
      assign w_x     = g_st[k-1].g_fwd.r_a[CHUNK-1:0];
      assign w_y     = g_st[k-1].g_fwd.r_b[CHUNK-1:0];
      assign w_ci    = g_st[k-1].r_c;
      assign w_vin   = r_vld[k-1];
      assign w_s_nxt = {w_res[CHUNK-1:0], g_st[k-1].r_s};
    end

    assign w_res = cla_chunk(w_x, w_y, w_ci);
    // Data only moves with a valid token so idle operand wiggles are ignored.
    assign w_ld  = w_adv[k] && w_vin;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_ld) begin
        r_s <= w_s_nxt;
        r_c <= w_res[CHUNK];
      end
    end

    if (REM > 0) begin : g_fwd
      logic [REM-1:0] r_a, r_b, w_ah, w_bh;
      if (k == 0) begin : g_hi
        assign w_ah = a[WIDTH-1:CHUNK];
        assign w_bh = w_bx[WIDTH-1:CHUNK];
      end else begin : g_hi
        assign w_ah = g_st[k-1].g_fwd.r_a[REM+CHUNK-1:CHUNK];
        assign w_bh = g_st[k-1].g_fwd.r_b[REM+CHUNK-1:CHUNK];
      end
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ld) begin
          r_a <= w_ah;
          r_b <= w_bh;
        end
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign s         = g_st[STAGES-1].r_s;
  assign cout      = g_st[STAGES-1].r_c;

`ifdef CLA_FLAGS_EN
  logic r_ovf, r_zero, w_cmsb;
  // Carry into the MSB recovered from its sum bit and propagate term.
  assign w_cmsb = g_st[STAGES-1].w_res[CHUNK-1] ^ g_st[STAGES-1].w_x[CHUNK-1]
                ^ g_st[STAGES-1].w_y[CHUNK-1];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (g_st[STAGES-1].w_ld) begin
      r_ovf  <= w_cmsb ^ g_st[STAGES-1].w_res[CHUNK];
      r_zero <= (g_st[STAGES-1].w_s_nxt == '0);
    end
  end
  assign ovf  = r_ovf;
  assign zero = r_zero;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: doc/pipe_cla_addsub.md
PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32: operand/result width in bits, a multiple of BLOCK.
REQ-002 The block SHALL expose parameter BLOCK, default 8: carry-lookahead block width in bits.
REQ-003 The block SHALL expose parameter STAGES, default 2: pipeline register stages; 1..WIDTH/BLOCK, dividing WIDTH/BLOCK evenly.
REQ-004 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1: operands present.
REQ-007 The block SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-008 The block SHALL have port a, input, WIDTH: first operand.
REQ-009 The block SHALL have port b, input, WIDTH: second operand.
REQ-010 The block SHALL have port cin, input, 1: carry in, used when sub=0.
REQ-011 The block SHALL have port sub, input, 1: 1 computes a-b (b inverted, carry-in forced 1, cin ignored).
REQ-012 The block SHALL have port out_valid, output, 1: result present.
REQ-013 The block SHALL have port out_ready, input, 1: consumer accepts result.
REQ-014 The block SHALL have port s, output, WIDTH: sum/difference, modulo 2^WIDTH.
REQ-015 The block SHALL have port cout, output, 1: carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-016 The block SHALL have port ovf, output, 1: signed two's-complement overflow.
REQ-017 The block SHALL have port zero, output, 1: s equals 0.

Function
REQ-018 Each BLOCK-bit slice SHALL form bit generate/propagate, a prefix lookahead carry chain, and block-level P/G; sum = a^b'^carry per bit.
REQ-019 Slices SHALL be split evenly over STAGES; stage k resolves its slices using the carry registered from stage k-1 and registers its sum bits, the carry out, and still-unprocessed operand bits.
REQ-020 Latency SHALL be exactly STAGES cycles from accepted input (in_valid&in_ready) to out_valid with no stall; throughput one operation per cycle.
REQ-021 Each stage SHALL hold a valid bit; stage k advances when empty or stage k+1 advances; last stage advances when out_ready or !out_valid.
REQ-022 in_ready SHALL be high when stage 0 is empty or advancing; it SHALL be combinational from out_ready through the stage chain (no skid buffer).
REQ-023 While out_valid=1 and out_ready=0, s, cout, ovf, zero and out_valid SHALL hold stable; no accepted operation SHALL be lost or duplicated.
REQ-024 in_valid=0 SHALL insert a bubble; bubbles collapse when downstream stalls.
REQ-025 Result ordering SHALL equal acceptance order.
REQ-026 ovf SHALL equal carry into bit WIDTH-1 XOR cout.
REQ-027 Operand values with in_valid=0 SHALL NOT change any stage contents.

Reset
REQ-028 resetn=0 SHALL asynchronously clear all stage valid bits, giving out_valid=0, s=0, cout=0, ovf=0, zero=0.
REQ-029 Operations in flight when resetn asserts SHALL be discarded; in_ready SHALL be 1 from the first edge after resetn deasserts.

Configuration
REQ-030 With macro CLA_FLAGS_EN defined, ovf and zero SHALL be computed in the last stage and registered with s.
REQ-031 Without CLA_FLAGS_EN, ovf and zero SHALL be tied to 0 and no flag logic SHALL be synthesised; s, cout and timing SHALL be unchanged.

Verification (WIDTH=32, BLOCK=8, STAGES=2, CLA_FLAGS_EN defined)
REQ-032 a=FFFFFFFF, b=00000001, cin=0, sub=0, out_ready=1 -> 2 cycles later s=00000000, cout=1, zero=1, ovf=0.
REQ-033 a=7FFFFFFF, b=00000001, sub=0 -> s=80000000, cout=0, ovf=1, zero=0.
REQ-034 a=00000005, b=00000007, sub=1, cin=1 -> s=FFFFFFFE, cout=0, ovf=0 (cin ignored).
REQ-035 Ten back-to-back random ops with out_ready=0 for cycles 3-6 -> in_ready low while stages full, results emitted in order, each matching a+b+cin reference model.
REQ-036 resetn pulsed low mid-stream with two ops in flight -> out_valid=0 immediately, no stale result emitted after reset release.
